conv_blur_3x3: RTL
==================

CONV_BLUR_3X3 -- requirements
Module: conv_blur_3x3

Interface
REQ-001 Parameter WIDTH, default 640, meaning pixels per line.
REQ-002 Parameter HEIGHT, default 480, meaning lines per frame.
REQ-003 Parameter BUS_SIZE, default 24, meaning pixel width as three 8-bit channels, R in [23:16], G in [15:8], B in [7:0].
REQ-004 The block shall have one clock; reset is asynchronous and active-low, with ports clock and reset_n.
REQ-005 Port clock, input, 1, rising-edge system clock.
REQ-006 Port reset_n, input, 1, asynchronous active-low reset.
REQ-007 Port EN, input, 1, pixel strobe; the window is current on this cycle.
REQ-008 Port sof, input, 1, qualified by EN; marks the first pixel of a frame.
REQ-009 Port window, input, [BUS_SIZE-1:0] x 3 x 3, 3x3 neighbourhood from the upstream sliding window; [1][1] is the centre tap.
REQ-010 Port flush_en, output, 1, upstream shift request during FLUSH; the integrator ORs it into the upstream EN.
REQ-011 Port busy, output, 1, high in FLUSH; upstream shall not strobe EN.
REQ-012 Port out_valid, output, 1, out_pixel/out_x/out_y valid.
REQ-013 Port out_pixel, output, BUS_SIZE, filtered pixel.
REQ-014 Port out_x, output, clog2(WIDTH), output column.
REQ-015 Port out_y, output, clog2(HEIGHT), output row.
REQ-016 Port frame_done, output, 1, one-cycle pulse with the output at (WIDTH-1, HEIGHT-1).
REQ-017 Port overrun, output, 1, sticky error: EN seen while busy.

Function
REQ-018 FSM states: IDLE, RUN, FLUSH.
- IDLE->RUN on EN&&sof.
- RUN->FLUSH on the strobe with input index k = WIDTH*HEIGHT-1.
- FLUSH->IDLE after WIDTH+1 flush cycles.
REQ-019 In IDLE, EN without sof shall be ignored and produce no output.
REQ-020 Input index k counts strobes from 0 at sof; the strobe at index k has centre pixel index c = k-(WIDTH+1), with no output while k < WIDTH+1.
REQ-021 The centre coordinate is tracked by x/y counters that wrap x at WIDTH-1 and increment y on wrap.
REQ-022 The kernel is [1 2 1; 2 4 2; 1 2 1] per channel, result = (sum+8)>>4.
REQ-023 The kernel shall produce an exact 8-bit result per channel with no saturation.
REQ-024 Stage 1 shall register row sums at 10 bits.
REQ-025 Stage 2 shall register the total at 12 bits, then round and shift.
REQ-026 If the centre lies on row 0, row HEIGHT-1, column 0 or column WIDTH-1, out_pixel shall equal window[1][1] unchanged.
REQ-027 Latency: out_valid shall assert exactly 2 clocks after the producing strobe.
REQ-028 The pipeline shall be free-running and independent of later strobes.
REQ-029 FLUSH shall assert flush_en and busy for exactly WIDTH+1 consecutive cycles.
REQ-030 Each flush cycle shall be treated as a strobe so that the last WIDTH+1 centres are emitted.
REQ-031 EN during FLUSH shall set overrun, shall not advance the counters, and shall not alter the flush count.
REQ-032 sof with EN in RUN mid-frame shall restart at k = 0, and in-flight pipeline outputs shall still emit.
REQ-033 frame_done shall be coincident with out_valid for (WIDTH-1, HEIGHT-1).

Reset
REQ-034 On reset_n low, the FSM shall go to IDLE and the counters to 0.
REQ-035 On reset_n low, out_valid, out_pixel, out_x, out_y, flush_en, busy, frame_done and overrun shall be 0, and the pipeline valids shall clear.
REQ-036 Reset mid-frame or mid-flush shall discard in-flight data, and no out_valid shall follow the reset.

Structure
REQ-037 Package blur_pkg shall hold the FSM state enum, the kernel weight constants, the rounding constant 8 and the shift 4.
REQ-038 Sub-module blur_channel shall implement the 2-stage 8-bit channel arithmetic and shall be instantiated three times.

Verification
REQ-039 With WIDTH=4 and HEIGHT=3, a constant frame of 0x646464 shall give 12 outputs all 0x646464 and a frame_done pulse.
REQ-040 With WIDTH=4 and HEIGHT=3, an impulse of 0xFF on all channels at (1,1) shall give (1,1)=0x404040, (2,1)=0x202020, and (1,0) passthrough 0x000000.
REQ-041 After the 12th strobe, busy and flush_en shall be high for exactly 5 cycles, the FSM shall return to IDLE, and out_valid shall lag every strobe by 2 clocks.
REQ-042 EN pulsed during FLUSH shall set overrun, overrun shall stay high until reset, and the output count shall remain 12.
REQ-043 A reset_n pulse at k=7 shall be followed by no out_valid until a new sof, after which a full frame shall complete correctly.
REQ-044 sof re-asserted at k=9 shall emit the remaining in-flight outputs, then restart coordinates at (0,0).

Source files
------------

// File: rtl/blur_pkg.sv
// Shared types and kernel constants for the 3x3 Gaussian blur.
// The kernel [1 2 1; 2 4 2; 1 2 1] is the outer product of [1 2 1] with itself.
package blur_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH
  } state_t;

  // 1-D weights; the 2-D kernel weight at (r, c) is K_1D[r] * K_1D[c].
  localparam int K_SIDE  = 1;
  localparam int K_MID   = 2;
  localparam int ROUND   = 8;
  localparam int SHIFT   = 4;
  localparam int ROW_W   = 10;
  localparam int TOTAL_W = 12;

  function automatic logic [ROW_W-1:0] row_sum(input logic [7:0] a, input logic [7:0] b,
                                               input logic [7:0] c);
    return ROW_W'(int'(a) * K_SIDE + int'(b) * K_MID + int'(c) * K_SIDE);
  endfunction

  function automatic logic [TOTAL_W-1:0] col_sum(input logic [ROW_W-1:0] a,
                                                 input logic [ROW_W-1:0] b,
                                                 input logic [ROW_W-1:0] c);
    return TOTAL_W'(int'(a) * K_SIDE + int'(b) * K_MID + int'(c) * K_SIDE);
  endfunction

  // Max total is 16*255 = 4080, so the rounded result always fits in 8 bits.
  function automatic logic [7:0] round_shift(input logic [TOTAL_W-1:0] total);
    return 8'((int'(total) + ROUND) >> SHIFT);
  endfunction

endpackage

// File: rtl/blur_channel.sv
// Two-stage blur arithmetic for one 8-bit channel: row sums, then rounded total.
// Border pixels bypass the kernel and pass the centre tap through unchanged.
module blur_channel
  import blur_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [2:0][2:0][7:0] taps,
  input  logic                 bypass,
  output logic [7:0]           pixel
);

  logic [2:0][ROW_W-1:0] row_q;
  logic [TOTAL_W-1:0]    total_q;
  logic [7:0]            centre_q1;
  logic [7:0]            centre_q2;
  logic                  bypass_q1;
  logic                  bypass_q2;

  // NOTE: datapath registers are reset too, so out_pixel reads 0 straight out of reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      row_q     <= '0;
      total_q   <= '0;
      centre_q1 <= '0;
      centre_q2 <= '0;
      bypass_q1 <= 1'b0;
      bypass_q2 <= 1'b0;
    end else begin
      // NOTE: non-blocking so stage 2 consumes the previous stage-1 values.
      for (int r = 0; r < 3; r++) begin
        row_q[r] <= row_sum(taps[r][0], taps[r][1], taps[r][2]);
      end
      centre_q1 <= taps[1][1];
      bypass_q1 <= bypass;
      total_q   <= col_sum(row_q[0], row_q[1], row_q[2]);
      centre_q2 <= centre_q1;
      bypass_q2 <= bypass_q1;
    end
  end

  assign pixel = bypass_q2 ? centre_q2 : round_shift(total_q);

endmodule

// File: rtl/conv_blur_3x3.sv
// 3x3 blur on a streamed sliding window: tracks frame position, drives a
// FLUSH phase to drain the last WIDTH+1 centres, and emits coordinates with each pixel.
module conv_blur_3x3
  import blur_pkg::*;
#(
  parameter int WIDTH    = 640,
  parameter int HEIGHT   = 480,
  parameter int BUS_SIZE = 24
) (
  input  logic                               clock,
  input  logic                               reset_n,
  input  logic                               EN,
  input  logic                               sof,
  input  logic [2:0][2:0][BUS_SIZE-1:0]      window,
  output logic                               flush_en,
  output logic                               busy,
  output logic                               out_valid,
  output logic [BUS_SIZE-1:0]                out_pixel,
  output logic [$clog2(WIDTH)-1:0]           out_x,
  output logic [$clog2(HEIGHT)-1:0]          out_y,
  output logic                               frame_done,
  output logic                               overrun
);

  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);
  localparam int KW = $clog2(WIDTH * HEIGHT);
  localparam int FW = $clog2(WIDTH + 1);

  state_t          state;
  logic [KW-1:0]   k;
  logic [KW-1:0]   k_eff;
  logic [XW-1:0]   cx;
  logic [YW-1:0]   cy;
  logic [FW-1:0]   flush_cnt;
  logic            strobe_run;
  logic            restart;
  logic            emit;
  logic            bypass;
  logic            is_last;

  logic            valid_q1, valid_q2;
  logic            last_q1, last_q2;
  logic [XW-1:0]   x_q1, x_q2;
  logic [YW-1:0]   y_q1, y_q2;

  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    strobe_run = 1'b0;
    restart    = 1'b0;
    k_eff      = k;
    emit       = 1'b0;
    strobe_run = (state == RUN) && EN;
    restart    = EN && sof && (state != FLUSH);
    if (restart) k_eff = '0;
    // Flush cycles stand in for strobes so the trailing centres still come out.
    emit = (state == FLUSH) || (strobe_run && (k_eff >= KW'(WIDTH + 1)));
  end

  assign bypass  = (cx == '0) || (cx == XW'(WIDTH - 1)) || (cy == '0) || (cy == YW'(HEIGHT - 1));
  assign is_last = (cx == XW'(WIDTH - 1)) && (cy == YW'(HEIGHT - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      k         <= '0;
      cx        <= '0;
      cy        <= '0;
      flush_cnt <= '0;
      busy      <= 1'b0;
      flush_en  <= 1'b0;
      overrun   <= 1'b0;
      valid_q1  <= 1'b0;
      valid_q2  <= 1'b0;
      last_q1   <= 1'b0;
      last_q2   <= 1'b0;
      x_q1      <= '0;
      x_q2      <= '0;
      y_q1      <= '0;
      y_q2      <= '0;
    end else begin
      valid_q1 <= emit;
      last_q1  <= emit && is_last;
      x_q1     <= cx;
      y_q1     <= cy;
      valid_q2 <= valid_q1;
      last_q2  <= last_q1;
      x_q2     <= x_q1;
      y_q2     <= y_q1;

      if (restart) begin
        cx <= '0;
        cy <= '0;
      end else if (emit) begin
        if (cx == XW'(WIDTH - 1)) begin
          cx <= '0;
          cy <= (cy == YW'(HEIGHT - 1)) ? '0 : cy + YW'(1);
        end else begin
          cx <= cx + XW'(1);
        end
      end

      case (state)
        IDLE: begin
          if (restart) begin
            state <= RUN;
            k     <= KW'(1);
          end
        end
        RUN: begin
          if (strobe_run) begin
            if (k_eff == KW'(WIDTH * HEIGHT - 1)) begin
              state     <= FLUSH;
              busy      <= 1'b1;
              flush_en  <= 1'b1;
              flush_cnt <= '0;
            end else begin
              k <= k_eff + KW'(1);
            end
          end
        end
        FLUSH: begin
          if (EN) overrun <= 1'b1;
          if (flush_cnt == FW'(WIDTH)) begin
            state    <= IDLE;
            busy     <= 1'b0;
            flush_en <= 1'b0;
            k        <= '0;
          end else begin
            flush_cnt <= flush_cnt + FW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < 3; g++) begin : g_ch
    logic [2:0][2:0][7:0] taps;

    always_comb begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          taps[r][c] = window[r][c][8*g +: 8];
        end
      end
    end

    blur_channel u_channel (
      .clock   (clock),
      .reset_n (reset_n),
      .taps    (taps),
      .bypass  (bypass),
      .pixel   (out_pixel[8*g +: 8])
    );
  end

  assign out_valid  = valid_q2;
  assign out_x      = x_q2;
  assign out_y      = y_q2;
  assign frame_done = valid_q2 && last_q2;

endmodule
